// File: rtl/fp64_mul_round_pack_if.sv
// Handshake bundle between the Vedic significand array and the round/pack stage.
// The upstream side drives the operand bundle; the downstream side drives out_ready.
interface fp64_mul_round_pack_if;
   logic         in_valid;
   logic         in_ready;
   logic         sign_in;
   logic [10:0]  exp_a;
   logic [10:0]  exp_b;
   logic         frac_a_nz;
   logic         frac_b_nz;
   logic [105:0] mant_prod;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  result;
   logic [3:0]   flags;

   modport master (
      output in_valid, sign_in, exp_a, exp_b, frac_a_nz, frac_b_nz, mant_prod, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, sign_in, exp_a, exp_b, frac_a_nz, frac_b_nz, mant_prod, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp64_mul_round_pack.sv
// Final stage of the binary64 Vedic multiplier: normalise, round to nearest-even,
// resolve special operands and pack the result. Two register stages with a
// valid/ready handshake; flags are {invalid, overflow, underflow, inexact}.
module fp64_mul_round_pack #(
   parameter int unsigned BIAS = 1023
) (
   input logic                  clk,
   input logic                  rst_n,
   fp64_mul_round_pack_if.slave bus
);

   typedef enum logic [1:0] {KNorm, KNan, KInf, KZero} kind_e;

   localparam logic [12:0] BiasW = 13'(BIAS);
   localparam logic [63:0] QNan  = 64'h7FF8_0000_0000_0000;

   // Handshake
   logic w_s2_adv;
   logic w_s1_adv;

   // Stage 1 registers
   logic               r_s1_valid;
   kind_e              r_s1_kind;
   logic               r_s1_invalid;
   logic               r_s1_sign;
   logic signed [12:0] r_s1_exp;
   logic [51:0]        r_s1_frac;
   logic               r_s1_g;
   logic               r_s1_s;

   // Stage 2 registers
   logic        r_s2_valid;
   logic [63:0] r_result;
   logic [3:0]  r_flags;

   // Stage 1 combinational
   logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
   logic               w_inf_zero;
   kind_e              w_kind;
   logic               w_bump;
   logic [51:0]        w_frac;
   logic               w_g;
   logic               w_s;
   logic signed [12:0] w_exp;

   // Stage 2 combinational
   logic               w_rnd_up;
   logic [52:0]        w_frac_inc;
   logic signed [12:0] w_exp_fin;
   logic [63:0]        w_result;
   logic [3:0]         w_flags;

   assign w_s2_adv     = !r_s2_valid || bus.out_ready;
   assign w_s1_adv     = !r_s1_valid || w_s2_adv;
   assign bus.in_ready = w_s1_adv;
   assign bus.out_valid = r_s2_valid;
   assign bus.result   = r_result;
   assign bus.flags    = r_flags;

   // Classify operands (subnormals count as zero) and normalise the product.
   always_comb begin
      w_a_zero   = (bus.exp_a == 11'd0);
      w_b_zero   = (bus.exp_b == 11'd0);
      w_a_inf    = (bus.exp_a == 11'h7FF) && !bus.frac_a_nz;
      w_b_inf    = (bus.exp_b == 11'h7FF) && !bus.frac_b_nz;
      w_a_nan    = (bus.exp_a == 11'h7FF) && bus.frac_a_nz;
      w_b_nan    = (bus.exp_b == 11'h7FF) && bus.frac_b_nz;
      w_inf_zero = (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);

      w_kind = KNorm;
      if (w_a_nan || w_b_nan || w_inf_zero) begin
         w_kind = KNan;
      end else if (w_a_inf || w_b_inf) begin
         w_kind = KInf;
      end else if (w_a_zero || w_b_zero) begin
         w_kind = KZero;
      end

      w_bump = bus.mant_prod[105];
      if (w_bump) begin
         w_frac = bus.mant_prod[104:53];
         w_g    = bus.mant_prod[52];
         w_s    = |bus.mant_prod[51:0];
      end else begin
         w_frac = bus.mant_prod[103:52];
         w_g    = bus.mant_prod[51];
         w_s    = |bus.mant_prod[50:0];
      end
      // 13 bits covers [-1021, 3070] so the sum never wraps.
      w_exp = {2'b00, bus.exp_a} + {2'b00, bus.exp_b} - BiasW + {12'd0, w_bump};
   end

   // Stage 1 register: capture classified, normalised bundle when S1 advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_kind    <= KNorm;
         r_s1_invalid <= 1'b0;
         r_s1_sign    <= 1'b0;
         r_s1_exp     <= '0;
         r_s1_frac    <= '0;
         r_s1_g       <= 1'b0;
         r_s1_s       <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_kind    <= w_kind;
            r_s1_invalid <= w_inf_zero;
            r_s1_sign    <= bus.sign_in;
            r_s1_exp     <= w_exp;
            r_s1_frac    <= w_frac;
            r_s1_g       <= w_g;
            r_s1_s       <= w_s;
         end
      end
   end

   // Round to nearest-even, range-check the exponent and pack.
   always_comb begin
      w_rnd_up   = r_s1_g && (r_s1_s || r_s1_frac[0]);
      w_frac_inc = {1'b0, r_s1_frac} + {52'd0, w_rnd_up};
      // On carry-out the low 52 bits are already zero.
      w_exp_fin  = r_s1_exp + {12'd0, w_frac_inc[52]};

      w_result = '0;
      w_flags  = '0;
      case (r_s1_kind)
         KNan: begin
            w_result = QNan;
            w_flags  = {r_s1_invalid, 3'b000};
         end
         KInf: begin
            w_result = {r_s1_sign, 11'h7FF, 52'd0};
         end
         KZero: begin
            w_result = {r_s1_sign, 63'd0};
         end
         default: begin
            if (w_exp_fin >= 13'sd2047) begin
               w_result = {r_s1_sign, 11'h7FF, 52'd0};
               w_flags  = 4'b0101;
            end else if (w_exp_fin <= 13'sd0) begin
               w_result = {r_s1_sign, 63'd0};
               w_flags  = 4'b0011;
            end else begin
               w_result = {r_s1_sign, w_exp_fin[10:0], w_frac_inc[51:0]};
               w_flags  = {3'b000, r_s1_g | r_s1_s};
            end
         end
      endcase
   end

   // Stage 2 register: output holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_flags    <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result <= w_result;
            r_flags  <= w_flags;
         end
      end
   end

endmodule

// File: tb/tb_fp64_mul_round_pack.sv
// Directed bench for fp64_mul_round_pack: arithmetic, rounding, specials,
// range limits, back-to-back throughput, stalls and mid-stream reset.
module tb_fp64_mul_round_pack;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   fp64_mul_round_pack_if u_if ();

   fp64_mul_round_pack #(.BIAS(1023)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one bundle into an empty pipeline and wait (bounded) for its result.
   // lat = -1 when no result appeared.
   task automatic send_one(input logic sg, input logic [10:0] ea, input logic [10:0] eb,
                           input logic fa, input logic fb, input logic [105:0] p,
                           output logic [63:0] res, output logic [3:0] flg, output int lat);
      @(negedge clk);
      u_if.out_ready = 1'b1;
      u_if.in_valid  = 1'b1;
      u_if.sign_in   = sg;
      u_if.exp_a     = ea;
      u_if.exp_b     = eb;
      u_if.frac_a_nz = fa;
      u_if.frac_b_nz = fb;
      u_if.mant_prod = p;
      @(negedge clk);
      u_if.in_valid = 1'b0;
      lat = -1;
      res = '0;
      flg = '0;
      for (int c = 1; c <= 8; c++) begin
         if (u_if.out_valid) begin
            lat = c;
            res = u_if.result;
            flg = u_if.flags;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b0;
      u_if.sign_in   = 1'b0;
      u_if.exp_a     = '0;
      u_if.exp_b     = '0;
      u_if.frac_a_nz = 1'b0;
      u_if.frac_b_nz = 1'b0;
      u_if.mant_prod = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (u_if.out_valid !== 1'b0 || u_if.result !== 64'd0 || u_if.flags !== 4'd0) begin
         errors++;
         $display("FAIL reset_state out_valid=%b result=%h flags=%b expected 0/0/0",
                  u_if.out_valid, u_if.result, u_if.flags);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (u_if.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b expected=1", u_if.in_ready);
      end
   endtask

   task automatic test_basic();
      logic        sg_v [3];
      logic [10:0] ea_v [3];
      logic [10:0] eb_v [3];
      logic [105:0] p_v [3];
      logic [63:0] er_v [3];
      logic [63:0] res;
      logic [3:0]  flg;
      int          lat;
      sg_v = '{1'b0, 1'b1, 1'b0};
      ea_v = '{11'd1023, 11'd1023, 11'd1023};
      eb_v = '{11'd1023, 11'd1024, 11'd1023};
      p_v[0] = 106'd1 << 104;
      p_v[1] = 106'd3 << 103;
      p_v[2] = 106'd9 << 102;
      er_v = '{64'h3FF0_0000_0000_0000, 64'hC008_0000_0000_0000, 64'h4002_0000_0000_0000};
      for (int i = 0; i < 3; i++) begin
         send_one(sg_v[i], ea_v[i], eb_v[i], 1'b0, 1'b0, p_v[i], res, flg, lat);
         checks++;
         if (lat !== 2) begin
            errors++;
            $display("FAIL basic_latency[%0d] got=%0d expected=2", i, lat);
         end
         checks++;
         if (res !== er_v[i] || flg !== 4'b0000) begin
            errors++;
            $display("FAIL basic_result[%0d] got=%h/%b expected=%h/0000", i, res, flg, er_v[i]);
         end
      end
   endtask

   task automatic test_rounding();
      logic [105:0] p_v [6];
      logic [63:0]  er_v [6];
      logic [105:0] ones;
      logic [63:0]  res;
      logic [3:0]   flg;
      int           lat;
      ones   = {54'd0, 52'hF_FFFF_FFFF_FFFF} << 52;
      p_v[0] = (106'd1 << 104) | (106'd1 << 51);
      p_v[1] = (106'd1 << 104) | (106'd1 << 52) | (106'd1 << 51);
      p_v[2] = (106'd1 << 104) | ones | (106'd1 << 51);
      p_v[3] = (106'd1 << 104) | (106'd1 << 51) | 106'd1;
      p_v[4] = (106'd1 << 104) | 106'd1;
      p_v[5] = (106'd1 << 105) | (106'd1 << 53) | (106'd1 << 52);
      er_v = '{64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0002, 64'h4000_0000_0000_0000,
               64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0002};
      for (int i = 0; i < 6; i++) begin
         send_one(1'b0, 11'd1023, 11'd1023, 1'b1, 1'b1, p_v[i], res, flg, lat);
         checks++;
         if (lat !== 2 || res !== er_v[i] || flg !== 4'b0001) begin
            errors++;
            $display("FAIL rounding[%0d] got=%h/%b lat=%0d expected=%h/0001 lat=2",
                     i, res, flg, lat, er_v[i]);
         end
      end
   endtask

   task automatic test_special();
      logic        sg_v [7];
      logic [10:0] ea_v [7];
      logic [10:0] eb_v [7];
      logic        fa_v [7];
      logic [63:0] er_v [7];
      logic [3:0]  ef_v [7];
      logic [63:0] res;
      logic [3:0]  flg;
      int          lat;
      sg_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      ea_v = '{11'd2047, 11'd0, 11'd2047, 11'd2047, 11'd0, 11'd0, 11'd2047};
      eb_v = '{11'd0, 11'd2047, 11'd1023, 11'd1000, 11'd1023, 11'd1023, 11'd0};
      fa_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      er_v = '{64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000,
               64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000,
               64'h7FF8_0000_0000_0000};
      ef_v = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 7; i++) begin
         send_one(sg_v[i], ea_v[i], eb_v[i], fa_v[i], 1'b0, (106'd3 << 104) | 106'd5,
                  res, flg, lat);
         checks++;
         if (lat !== 2 || res !== er_v[i] || flg !== ef_v[i]) begin
            errors++;
            $display("FAIL special[%0d] got=%h/%b lat=%0d expected=%h/%b lat=2",
                     i, res, flg, lat, er_v[i], ef_v[i]);
         end
      end
   endtask

   task automatic test_range();
      logic        sg_v [6];
      logic [10:0] ea_v [6];
      logic [10:0] eb_v [6];
      logic [105:0] p_v [6];
      logic [63:0] er_v [6];
      logic [3:0]  ef_v [6];
      logic [105:0] ones;
      logic [63:0] res;
      logic [3:0]  flg;
      int          lat;
      ones = {54'd0, 52'hF_FFFF_FFFF_FFFF} << 52;
      sg_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ea_v = '{11'd2046, 11'd1, 11'd2046, 11'd2046, 11'd1, 11'd1};
      eb_v = '{11'd1024, 11'd1, 11'd1023, 11'd1023, 11'd1023, 11'd1022};
      p_v[0] = 106'd1 << 104;
      p_v[1] = 106'd1 << 104;
      p_v[2] = (106'd1 << 104) | ones;
      p_v[3] = (106'd1 << 104) | ones | (106'd1 << 51);
      p_v[4] = 106'd1 << 104;
      p_v[5] = 106'd1 << 104;
      er_v = '{64'h7FF0_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF,
               64'h7FF0_0000_0000_0000, 64'h0010_0000_0000_0000, 64'h0000_0000_0000_0000};
      ef_v = '{4'b0101, 4'b0011, 4'b0000, 4'b0101, 4'b0000, 4'b0011};
      for (int i = 0; i < 6; i++) begin
         send_one(sg_v[i], ea_v[i], eb_v[i], 1'b0, 1'b0, p_v[i], res, flg, lat);
         checks++;
         if (lat !== 2 || res !== er_v[i] || flg !== ef_v[i]) begin
            errors++;
            $display("FAIL range[%0d] got=%h/%b lat=%0d expected=%h/%b lat=2",
                     i, res, flg, lat, er_v[i], ef_v[i]);
         end
      end
   endtask

   // Four bundles on consecutive cycles; results must come out on consecutive cycles.
   task automatic test_back_to_back();
      logic [63:0] exp_r;
      int          k;
      u_if.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 4) begin
            u_if.in_valid  = 1'b1;
            u_if.sign_in   = ((c % 2) == 1);
            u_if.exp_a     = 11'(1000 + c);
            u_if.exp_b     = 11'd1023;
            u_if.frac_a_nz = 1'b1;
            u_if.frac_b_nz = 1'b0;
            u_if.mant_prod = 106'd3 << 103;
         end else begin
            u_if.in_valid = 1'b0;
         end
         #1;
         if (c < 4) begin
            checks++;
            if (u_if.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_in_ready[%0d] got=%b expected=1", c, u_if.in_ready);
            end
         end
         checks++;
         if (u_if.out_valid !== (c >= 2 && c < 6)) begin
            errors++;
            $display("FAIL b2b_out_valid[%0d] got=%b expected=%b", c, u_if.out_valid,
                     (c >= 2 && c < 6));
         end else if (c >= 2 && c < 6) begin
            k     = c - 2;
            exp_r = {((k % 2) == 1), 11'(1000 + k), 52'h8_0000_0000_0000};
            checks++;
            if (u_if.result !== exp_r || u_if.flags !== 4'b0000) begin
               errors++;
               $display("FAIL b2b_result[%0d] got=%h/%b expected=%h/0000", k, u_if.result,
                        u_if.flags, exp_r);
            end
         end
      end
   endtask

   // Eight bundles with out_ready cycling 1,0,0,1: order, hold and in_ready checks.
   task automatic test_stall_stream();
      int          tx;
      int          rx;
      int          cyc;
      logic        ordy;
      logic        exp_rdy;
      logic        held_v;
      logic [63:0] held_r;
      logic [3:0]  held_f;
      logic [63:0] exp_r;
      tx     = 0;
      rx     = 0;
      cyc    = 0;
      held_v = 1'b0;
      held_r = '0;
      held_f = '0;
      while (rx < 8 && cyc < 200) begin
         @(negedge clk);
         ordy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         u_if.out_ready = ordy;
         if (tx < 8) begin
            u_if.in_valid  = 1'b1;
            u_if.sign_in   = 1'b0;
            u_if.exp_a     = 11'(1023 + tx);
            u_if.exp_b     = 11'd1023;
            u_if.frac_a_nz = 1'b0;
            u_if.frac_b_nz = 1'b0;
            u_if.mant_prod = 106'd1 << 104;
         end else begin
            u_if.in_valid = 1'b0;
         end
         #1;
         if (held_v) begin
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.result !== held_r || u_if.flags !== held_f) begin
               errors++;
               $display("FAIL stall_hold cyc=%0d got=%b/%h/%b expected=1/%h/%b", cyc,
                        u_if.out_valid, u_if.result, u_if.flags, held_r, held_f);
            end
         end
         // Two bundles in flight means both stages are occupied.
         exp_rdy = !((tx - rx) == 2 && !ordy);
         checks++;
         if (u_if.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL stall_in_ready cyc=%0d got=%b expected=%b", cyc, u_if.in_ready,
                     exp_rdy);
         end
         if (u_if.out_valid && ordy) begin
            exp_r = {1'b0, 11'(1023 + rx), 52'd0};
            checks++;
            if (u_if.result !== exp_r || u_if.flags !== 4'b0000) begin
               errors++;
               $display("FAIL stall_order[%0d] got=%h/%b expected=%h/0000", rx, u_if.result,
                        u_if.flags, exp_r);
            end
            rx++;
         end
         held_v = u_if.out_valid && !ordy;
         held_r = u_if.result;
         held_f = u_if.flags;
         if (u_if.in_valid && u_if.in_ready) tx++;
         cyc++;
      end
      @(negedge clk);
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b1;
      checks++;
      if (rx != 8 || tx != 8) begin
         errors++;
         $display("FAIL stall_count received=%0d sent=%0d expected=8/8", rx, tx);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (u_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_no_dup got out_valid=%b expected=0", u_if.out_valid);
      end
   endtask

   task automatic test_reset_mid_stream();
      int seen;
      u_if.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         u_if.in_valid  = 1'b1;
         u_if.sign_in   = 1'b1;
         u_if.exp_a     = 11'(1030 + i);
         u_if.exp_b     = 11'd1023;
         u_if.frac_a_nz = 1'b0;
         u_if.frac_b_nz = 1'b0;
         u_if.mant_prod = 106'd1 << 104;
      end
      @(negedge clk);
      u_if.in_valid = 1'b0;
      #1;
      checks++;
      if (u_if.out_valid !== 1'b1 || u_if.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_full out_valid=%b in_ready=%b expected=1/0", u_if.out_valid,
                  u_if.in_ready);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (u_if.out_valid !== 1'b0 || u_if.result !== 64'd0 || u_if.flags !== 4'd0) begin
         errors++;
         $display("FAIL rst_mid_async out_valid=%b result=%h flags=%b expected 0/0/0",
                  u_if.out_valid, u_if.result, u_if.flags);
      end
      @(negedge clk);
      rst_n          = 1'b1;
      u_if.out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (u_if.out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_mid_discard valid_cycles=%0d expected=0", seen);
      end
      checks++;
      if (u_if.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_in_ready got=%b expected=1", u_if.in_ready);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_rounding();
      test_special();
      test_range();
      test_back_to_back();
      test_stall_stream();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
